// File: rtl/spatial_filter_pkg.sv
// -----------------------------------------------------------------------------
// spatial_filter_pkg
// Shared types and constants for the spatial filter frame sequencer:
//   - seq_state_t      : frame sequencer FSM states
//   - NUM_LINE_BUFFERS : physical line buffers in the 3x3 window datapath
//   - WINDOW_LINES     : lines needed before one window row can be emitted
//   - cnt_width()      : bit width needed to hold 0..max_val
//   - FULL_W           : width of the buffer-occupancy counter
// -----------------------------------------------------------------------------
package spatial_filter_pkg;

  function automatic int unsigned cnt_width(input int unsigned max_val);
    return (max_val < 2) ? 1 : $clog2(max_val + 1);
  endfunction

  localparam int unsigned NUM_LINE_BUFFERS = 4;
  localparam int unsigned WINDOW_LINES     = 3;
  localparam int unsigned FULL_W           = cnt_width(NUM_LINE_BUFFERS);

  typedef enum logic [2:0] {
    SEQ_IDLE,
    SEQ_FILL,
    SEQ_ISSUE,
    SEQ_WAIT,
    SEQ_DONE
  } seq_state_t;

endpackage

// File: rtl/spatial_filter_line_occupancy.sv
// -----------------------------------------------------------------------------
// spatial_filter_line_occupancy
// Tracks write progress into the line buffers and how many completed lines
// are still held (not yet released by a finished output row).
// Optional macro: SPATIAL_FILTER_SEQ_ERR_CHECK_EN adds o_underflow.
// Ports:
//   clk, reset         : clock, synchronous active-high reset
//   i_clear            : clear all counters (start of a new frame)
//   i_active           : sequencer is in a pixel-accepting state
//   i_pixel_valid      : upstream pixel available
//   i_rd_release       : one output row finished, free one line buffer
//   o_pixel_ready      : pixel accepted this cycle (combinational)
//   o_wr_valid         : pixel valid & ready
//   o_full_lines       : current occupancy
//   o_full_lines_next  : occupancy after this cycle's updates
//   o_underflow        : release requested with no held line (optional)
// -----------------------------------------------------------------------------
module spatial_filter_line_occupancy
  import spatial_filter_pkg::*;
#(
  parameter int unsigned IMAGE_WIDTH  = 512,
  parameter int unsigned IMAGE_HEIGHT = 512
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              i_clear,
  input  logic              i_active,
  input  logic              i_pixel_valid,
  input  logic              i_rd_release,
  output logic              o_pixel_ready,
  output logic              o_wr_valid,
  output logic [FULL_W-1:0] o_full_lines,
  output logic [FULL_W-1:0] o_full_lines_next
`ifdef SPATIAL_FILTER_SEQ_ERR_CHECK_EN
  ,
  output logic              o_underflow
`endif
);

  localparam int unsigned PIX_W   = cnt_width(IMAGE_WIDTH - 1);
  localparam int unsigned LINES_W = cnt_width(IMAGE_HEIGHT);

  logic [PIX_W-1:0]   wr_pix_ctr_q, wr_pix_ctr_d;
  logic [LINES_W-1:0] lines_written_q, lines_written_d;
  logic [FULL_W-1:0]  full_lines_q, full_lines_d;
  logic               line_complete;

  assign o_pixel_ready = i_active
                      && (lines_written_q < LINES_W'(IMAGE_HEIGHT))
                      && (full_lines_q < FULL_W'(NUM_LINE_BUFFERS));
  assign o_wr_valid    = i_pixel_valid && o_pixel_ready;
  assign line_complete = o_wr_valid && (wr_pix_ctr_q == PIX_W'(IMAGE_WIDTH - 1));

  always_comb begin
    wr_pix_ctr_d    = wr_pix_ctr_q;
    lines_written_d = lines_written_q;
    full_lines_d    = full_lines_q;
`ifdef SPATIAL_FILTER_SEQ_ERR_CHECK_EN
    o_underflow     = 1'b0;
`endif
    if (i_clear) begin
      wr_pix_ctr_d    = '0;
      lines_written_d = '0;
      full_lines_d    = '0;
    end else begin
      if (o_wr_valid) begin
        if (line_complete) begin
          wr_pix_ctr_d    = '0;
          lines_written_d = lines_written_q + LINES_W'(1);
        end else begin
          wr_pix_ctr_d = wr_pix_ctr_q + PIX_W'(1);
        end
      end
      // A line landing in the same cycle a row is released nets to zero.
      case ({line_complete, i_rd_release})
        2'b10: full_lines_d = full_lines_q + FULL_W'(1);
        2'b01: begin
          if (full_lines_q != '0) full_lines_d = full_lines_q - FULL_W'(1);
`ifdef SPATIAL_FILTER_SEQ_ERR_CHECK_EN
          else o_underflow = 1'b1;
`endif
        end
        default: ;
      endcase
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      wr_pix_ctr_q    <= '0;
      lines_written_q <= '0;
      full_lines_q    <= '0;
    end else begin
      wr_pix_ctr_q    <= wr_pix_ctr_d;
      lines_written_q <= lines_written_d;
      full_lines_q    <= full_lines_d;
    end
  end

  assign o_full_lines      = full_lines_q;
  assign o_full_lines_next = full_lines_d;

endmodule

// File: rtl/spatial_filter_frame_sequencer.sv
// -----------------------------------------------------------------------------
// spatial_filter_frame_sequencer
// Frame-level controller for the 4-line-buffer 3x3 window datapath. Admits
// pixels under backpressure, requests one window row at a time once three
// lines are buffered, and ends the frame after IMAGE_HEIGHT-2 rows.
// Optional macro: SPATIAL_FILTER_SEQ_ERR_CHECK_EN adds sticky o_err[2:0]
//   bit0 stray i_line_rd_done, bit1 i_start while busy, bit2 occupancy underflow.
// Ports:
//   clk, reset      : clock, synchronous active-high reset
//   i_start         : frame start pulse (honoured only when idle)
//   i_pixel_valid   : upstream pixel available
//   o_pixel_ready   : pixel accepted this cycle
//   o_wr_valid      : datapath pixel-valid
//   o_rd_start      : request one IMAGE_WIDTH-pixel window row
//   i_line_rd_done  : requested row finished
//   o_busy          : frame in progress
//   o_frame_done    : end-of-frame pulse
//   o_rows_out      : completed output rows this frame
// -----------------------------------------------------------------------------
module spatial_filter_frame_sequencer
  import spatial_filter_pkg::*;
#(
  parameter int unsigned IMAGE_WIDTH      = 512,
  parameter int unsigned IMAGE_HEIGHT     = 512,
  parameter int unsigned NUM_LINE_BUFFERS = 4
) (
  input  logic                            clk,
  input  logic                            reset,
  input  logic                            i_start,
  input  logic                            i_pixel_valid,
  output logic                            o_pixel_ready,
  output logic                            o_wr_valid,
  output logic                            o_rd_start,
  input  logic                            i_line_rd_done,
  output logic                            o_busy,
  output logic                            o_frame_done,
  output logic [$clog2(IMAGE_HEIGHT)-1:0] o_rows_out
`ifdef SPATIAL_FILTER_SEQ_ERR_CHECK_EN
  ,
  output logic [2:0]                      o_err
`endif
);

  localparam int unsigned ROWS_W = $clog2(IMAGE_HEIGHT);

  if (NUM_LINE_BUFFERS != spatial_filter_pkg::NUM_LINE_BUFFERS) begin : g_bad_buffers
    $error("spatial_filter_frame_sequencer: NUM_LINE_BUFFERS must be 4");
  end
  if (IMAGE_HEIGHT < 3) begin : g_bad_height
    $error("spatial_filter_frame_sequencer: IMAGE_HEIGHT must be >= 3");
  end

  seq_state_t        state_q, state_d;
  logic [ROWS_W-1:0] rows_out_q, rows_out_d;
  logic              start_accept;
  logic              rd_release;
  logic              occ_active;
  logic [FULL_W-1:0] full_lines;
  logic [FULL_W-1:0] full_lines_next;

  assign start_accept = (state_q == SEQ_IDLE) && i_start;
  assign rd_release   = (state_q == SEQ_WAIT) && i_line_rd_done;
  assign occ_active   = (state_q != SEQ_IDLE) && (state_q != SEQ_DONE);

`ifdef SPATIAL_FILTER_SEQ_ERR_CHECK_EN
  logic       underflow;
  logic [2:0] err_q, err_d;
`endif

  spatial_filter_line_occupancy #(
    .IMAGE_WIDTH  (IMAGE_WIDTH),
    .IMAGE_HEIGHT (IMAGE_HEIGHT)
  ) u_occupancy (
    .clk               (clk),
    .reset             (reset),
    .i_clear           (start_accept),
    .i_active          (occ_active),
    .i_pixel_valid     (i_pixel_valid),
    .i_rd_release      (rd_release),
    .o_pixel_ready     (o_pixel_ready),
    .o_wr_valid        (o_wr_valid),
    .o_full_lines      (full_lines),
    .o_full_lines_next (full_lines_next)
`ifdef SPATIAL_FILTER_SEQ_ERR_CHECK_EN
    ,
    .o_underflow       (underflow)
`endif
  );

  always_comb begin
    state_d      = state_q;
    rows_out_d   = rows_out_q;
    o_rd_start   = 1'b0;
    o_frame_done = 1'b0;
    o_busy       = 1'b0;
    if (start_accept) rows_out_d = '0;
    if (rd_release)   rows_out_d = rows_out_q + ROWS_W'(1);
    case (state_q)
      SEQ_IDLE: begin
        if (i_start) state_d = SEQ_FILL;
      end
      SEQ_FILL: begin
        o_busy = 1'b1;
        if (full_lines >= FULL_W'(WINDOW_LINES)) state_d = SEQ_ISSUE;
      end
      SEQ_ISSUE: begin
        o_busy     = 1'b1;
        o_rd_start = 1'b1;
        state_d    = SEQ_WAIT;
      end
      SEQ_WAIT: begin
        o_busy = 1'b1;
        if (i_line_rd_done) begin
          // rows_out_q + 1 == IMAGE_HEIGHT - 2, written without the carry bit
          if (rows_out_q == ROWS_W'(IMAGE_HEIGHT - 3))             state_d = SEQ_DONE;
          else if (full_lines_next >= FULL_W'(WINDOW_LINES))       state_d = SEQ_ISSUE;
          else                                                     state_d = SEQ_FILL;
        end
      end
      SEQ_DONE: begin
        o_frame_done = 1'b1;
        state_d      = SEQ_IDLE;
      end
      default: state_d = SEQ_IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q    <= SEQ_IDLE;
      rows_out_q <= '0;
    end else begin
      state_q    <= state_d;
      rows_out_q <= rows_out_d;
    end
  end

  assign o_rows_out = rows_out_q;

`ifdef SPATIAL_FILTER_SEQ_ERR_CHECK_EN
  always_comb begin
    err_d    = start_accept ? '0 : err_q;
    err_d[0] = err_d[0] | (i_line_rd_done && (state_q != SEQ_WAIT));
    err_d[1] = err_d[1] | (i_start && o_busy);
    err_d[2] = err_d[2] | underflow;
  end

  always_ff @(posedge clk) begin
    if (reset) err_q <= '0;
    else       err_q <= err_d;
  end

  assign o_err = err_q;
`endif

endmodule

// File: tb/tb_spatial_filter_frame_sequencer.sv
module tb_spatial_filter_frame_sequencer;

  localparam int unsigned W = 8;
  localparam int unsigned H = 6;

  logic       clk = 1'b0;
  logic       reset;
  logic       i_start;
  logic       i_pixel_valid;
  logic       i_line_rd_done;
  logic       o_pixel_ready;
  logic       o_wr_valid;
  logic       o_rd_start;
  logic       o_busy;
  logic       o_frame_done;
  logic [2:0] o_rows_out;
`ifdef SPATIAL_FILTER_SEQ_ERR_CHECK_EN
  logic [2:0] o_err;
`endif

  int unsigned vectors     = 0;
  int unsigned miscompares = 0;

  always #5 clk = ~clk;

  spatial_filter_frame_sequencer #(
    .IMAGE_WIDTH      (W),
    .IMAGE_HEIGHT     (H),
    .NUM_LINE_BUFFERS (4)
  ) dut (
    .clk            (clk),
    .reset          (reset),
    .i_start        (i_start),
    .i_pixel_valid  (i_pixel_valid),
    .o_pixel_ready  (o_pixel_ready),
    .o_wr_valid     (o_wr_valid),
    .o_rd_start     (o_rd_start),
    .i_line_rd_done (i_line_rd_done),
    .o_busy         (o_busy),
    .o_frame_done   (o_frame_done),
    .o_rows_out     (o_rows_out)
`ifdef SPATIAL_FILTER_SEQ_ERR_CHECK_EN
    ,
    .o_err          (o_err)
`endif
  );

  // advance to 1 time unit after the next rising edge
  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic pulse_reset();
    reset = 1'b1; i_start = 1'b0; i_pixel_valid = 1'b0; i_line_rd_done = 1'b0;
    step();
    reset = 1'b0;
  endtask

  task automatic test_reset();
    reset = 1'b1; i_start = 1'b0; i_pixel_valid = 1'b1; i_line_rd_done = 1'b0;
    repeat (3) step();
    vectors++;
    if ({o_pixel_ready, o_wr_valid, o_rd_start, o_busy, o_frame_done, o_rows_out} !== 8'h00) begin
      miscompares++;
      $display("FAIL reset_outputs: got %b expected 00000000",
               {o_pixel_ready, o_wr_valid, o_rd_start, o_busy, o_frame_done, o_rows_out});
    end
    reset = 1'b0;
    step();
    vectors++;
    if (o_pixel_ready !== 1'b0 || o_busy !== 1'b0) begin
      miscompares++;
      $display("FAIL idle_not_ready: ready=%b busy=%b expected 0 0", o_pixel_ready, o_busy);
    end
`ifdef SPATIAL_FILTER_SEQ_ERR_CHECK_EN
    vectors++;
    if (o_err !== 3'b000) begin
      miscompares++;
      $display("FAIL reset_err: got %b expected 000", o_err);
    end
`endif
    i_pixel_valid = 1'b0;
  endtask

  // plans 2 and 3: first issue latency, then four-buffer backpressure
  task automatic test_fill_and_backpressure();
    int unsigned acc, guard, early, stray;
    i_start = 1'b1; i_pixel_valid = 1'b1;
    step();
    i_start = 1'b0;
    vectors++;
    if (o_busy !== 1'b1) begin
      miscompares++;
      $display("FAIL busy_after_start: got %b expected 1", o_busy);
    end
    acc = o_wr_valid ? 1 : 0;
    guard = 0; early = 0;
    while (acc < 24 && guard < 100) begin
      step(); guard++;
      if (o_rd_start) early++;
      if (o_wr_valid) acc++;
    end
    vectors++;
    if (acc !== 24 || early !== 0) begin
      miscompares++;
      $display("FAIL fill_24: accepted=%0d early_rd=%0d expected 24 0", acc, early);
    end
    step(); if (o_wr_valid) acc++;
    vectors++;
    if (o_rd_start !== 1'b0) begin
      miscompares++;
      $display("FAIL rd_start_plus1: got %b expected 0", o_rd_start);
    end
    step(); if (o_wr_valid) acc++;
    vectors++;
    if (o_rd_start !== 1'b1) begin
      miscompares++;
      $display("FAIL rd_start_plus2: got %b expected 1", o_rd_start);
    end
    step(); if (o_wr_valid) acc++;
    vectors++;
    if (o_rd_start !== 1'b0 || o_busy !== 1'b1) begin
      miscompares++;
      $display("FAIL rd_start_single: rd=%b busy=%b expected 0 1", o_rd_start, o_busy);
    end
    guard = 0;
    while (acc < 32 && guard < 100) begin
      step(); guard++;
      if (o_wr_valid) acc++;
    end
    stray = 0;
    repeat (5) begin
      step();
      if (o_pixel_ready || o_wr_valid) stray++;
    end
    vectors++;
    if (acc !== 32 || stray !== 0) begin
      miscompares++;
      $display("FAIL backpressure_4_lines: accepted=%0d stray=%0d expected 32 0", acc, stray);
    end
    i_line_rd_done = 1'b1;
    #1;
    vectors++;
    if (o_pixel_ready !== 1'b0) begin
      miscompares++;
      $display("FAIL ready_during_done: got %b expected 0", o_pixel_ready);
    end
    step();
    i_line_rd_done = 1'b0;
    #1;
    vectors++;
    if (o_pixel_ready !== 1'b1 || o_rows_out !== 3'd1) begin
      miscompares++;
      $display("FAIL ready_after_release: ready=%b rows=%0d expected 1 1", o_pixel_ready, o_rows_out);
    end
  endtask

  task automatic test_full_frame();
    int unsigned acc, guard, rd_cnt, done_cnt, cd;
    logic busy_at_done;
    pulse_reset();
    i_start = 1'b1; i_pixel_valid = 1'b1;
    step();
    i_start = 1'b0;
    acc = 0; guard = 0; rd_cnt = 0; done_cnt = 0; cd = 0; busy_at_done = 1'b1;
    while (done_cnt == 0 && guard < 400) begin
      if (o_wr_valid) acc++;
      if (o_rd_start) begin rd_cnt++; cd = 10; end
      if (o_frame_done) begin done_cnt++; busy_at_done = o_busy; end
      step(); guard++;
      i_line_rd_done = 1'b0;
      if (cd > 0) begin
        cd--;
        if (cd == 0) i_line_rd_done = 1'b1;
      end
      #1;
    end
    i_line_rd_done = 1'b0;
    vectors++;
    if (rd_cnt !== 4 || done_cnt !== 1 || acc !== 48) begin
      miscompares++;
      $display("FAIL frame_counts: rd=%0d done=%0d pix=%0d expected 4 1 48", rd_cnt, done_cnt, acc);
    end
    vectors++;
    if (o_rows_out !== 3'd4 || busy_at_done !== 1'b0) begin
      miscompares++;
      $display("FAIL frame_rows: rows=%0d busy_at_done=%b expected 4 0", o_rows_out, busy_at_done);
    end
    step();
    vectors++;
    if (o_pixel_ready !== 1'b0 || o_frame_done !== 1'b0 || o_busy !== 1'b0) begin
      miscompares++;
      $display("FAIL after_frame: ready=%b done=%b busy=%b expected 0 0 0",
               o_pixel_ready, o_frame_done, o_busy);
    end
  endtask

  task automatic test_simultaneous();
    int unsigned acc, guard, seen;
    i_line_rd_done = 1'b0;
    i_start = 1'b1; i_pixel_valid = 1'b1;
    step();
    i_start = 1'b0;
    acc = o_wr_valid ? 1 : 0;
    guard = 0;
    while (acc < 31 && guard < 100) begin
      step(); guard++;
      if (o_wr_valid) acc++;
    end
    step();
    i_line_rd_done = 1'b1;
    #1;
    vectors++;
    if (o_wr_valid !== 1'b1) begin
      miscompares++;
      $display("FAIL sim_pixel32: wr_valid=%b expected 1", o_wr_valid);
    end
    step();
    i_line_rd_done = 1'b0;
    #1;
    vectors++;
    if (o_pixel_ready !== 1'b1 || o_rows_out !== 3'd1) begin
      miscompares++;
      $display("FAIL sim_occupancy: ready=%b rows=%0d expected 1 1", o_pixel_ready, o_rows_out);
    end
    seen = o_rd_start ? 1 : 0;
    acc = o_wr_valid ? 1 : 0;
    guard = 0;
    while (acc < 8 && guard < 100) begin
      step(); guard++;
      if (o_rd_start) seen++;
      if (o_wr_valid) acc++;
    end
    step();
    vectors++;
    if (seen !== 1 || o_pixel_ready !== 1'b0) begin
      miscompares++;
      $display("FAIL sim_next_issue: rd_pulses=%0d ready=%b expected 1 0", seen, o_pixel_ready);
    end
  endtask

  task automatic test_reset_mid_frame();
    int unsigned guard, rd_cnt, cd, dones;
    pulse_reset();
    i_start = 1'b1; i_pixel_valid = 1'b1;
    step();
    i_start = 1'b0;
    guard = 0; rd_cnt = 0; cd = 0;
    while (rd_cnt < 3 && guard < 300) begin
      if (o_rd_start) begin rd_cnt++; if (rd_cnt < 3) cd = 3; end
      step(); guard++;
      i_line_rd_done = 1'b0;
      if (cd > 0) begin
        cd--;
        if (cd == 0) i_line_rd_done = 1'b1;
      end
      #1;
    end
    i_line_rd_done = 1'b0;
    step();
    // stray start mid-frame must not clear the row count
    i_start = 1'b1;
    step();
    i_start = 1'b0;
    #1;
    vectors++;
    if (rd_cnt !== 3 || o_rows_out !== 3'd2 || o_busy !== 1'b1) begin
      miscompares++;
      $display("FAIL pre_reset_state: rd=%0d rows=%0d busy=%b expected 3 2 1", rd_cnt, o_rows_out, o_busy);
    end
    reset = 1'b1;
    step();
    reset = 1'b0;
    vectors++;
    if (o_busy !== 1'b0 || o_rows_out !== 3'd0 || o_frame_done !== 1'b0 || o_pixel_ready !== 1'b0) begin
      miscompares++;
      $display("FAIL mid_reset: busy=%b rows=%0d done=%b ready=%b expected 0 0 0 0",
               o_busy, o_rows_out, o_frame_done, o_pixel_ready);
    end
    dones = 0;
    repeat (4) begin
      step();
      if (o_frame_done || o_busy) dones++;
    end
    vectors++;
    if (dones !== 0) begin
      miscompares++;
      $display("FAIL no_done_after_reset: got %0d active cycles expected 0", dones);
    end
`ifdef SPATIAL_FILTER_SEQ_ERR_CHECK_EN
    i_start = 1'b1;
    step();
    i_start = 1'b0;
    i_line_rd_done = 1'b1;
    step();
    i_line_rd_done = 1'b0;
    repeat (3) step();
    vectors++;
    if (o_err !== 3'b001) begin
      miscompares++;
      $display("FAIL err_stray_done: got %b expected 001", o_err);
    end
    i_start = 1'b1;
    step();
    i_start = 1'b0;
    #1;
    vectors++;
    if (o_err !== 3'b011) begin
      miscompares++;
      $display("FAIL err_busy_start: got %b expected 011", o_err);
    end
    pulse_reset();
    i_line_rd_done = 1'b1;
    step();
    i_line_rd_done = 1'b0;
    i_start = 1'b1;
    #1;
    vectors++;
    if (o_err !== 3'b001) begin
      miscompares++;
      $display("FAIL err_idle_stray: got %b expected 001", o_err);
    end
    step();
    i_start = 1'b0;
    #1;
    vectors++;
    if (o_err !== 3'b000) begin
      miscompares++;
      $display("FAIL err_clear_on_start: got %b expected 000", o_err);
    end
`endif
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1);
  end

  initial begin
    reset = 1'b1; i_start = 1'b0; i_pixel_valid = 1'b0; i_line_rd_done = 1'b0;
    test_reset();
    test_fill_and_backpressure();
    test_full_frame();
    test_simultaneous();
    test_reset_mid_frame();
    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
